// File: rtl/e203_longp_pkg.sv
// ---------------------------------------------------------------------------
// e203_longp_pkg
//   Shared types and constants for the long-pipe write-back reorder buffer.
//   - longp_res_t : one buffered long-pipe result (wdat, flags, rdidx, rdfpu, err)
//   - LONGP_FLAGS_W : FP exception flag width
//   - LONGP_SRC0 / LONGP_SRC1 : source select encoding (src0 has priority)
//   The struct is laid out with LONGP_FLEN / LONGP_RFIDX_W, so the top-level
//   FLEN / RFIDX_W parameters must keep these values.
// ---------------------------------------------------------------------------
package e203_longp_pkg;

    localparam int LONGP_FLAGS_W = 5;
    localparam int LONGP_FLEN    = 32;
    localparam int LONGP_RFIDX_W = 5;

    localparam logic LONGP_SRC0 = 1'b0;
    localparam logic LONGP_SRC1 = 1'b1;

    typedef struct packed {
        logic [LONGP_FLEN-1:0]    wdat;
        logic [LONGP_FLAGS_W-1:0] flags;
        logic [LONGP_RFIDX_W-1:0] rdidx;
        logic                     rdfpu;
        logic                     err;
    } longp_res_t;

    // src0 wins whenever it targets the slot.
    function automatic logic longp_src_sel(input logic src0_hit);
        return src0_hit ? LONGP_SRC0 : LONGP_SRC1;
    endfunction

endpackage

// File: rtl/e203_exu_longp_rob_slot.sv
// ---------------------------------------------------------------------------
// e203_exu_longp_rob_slot
//   One reorder-buffer entry: valid flag plus the stored result.
//   Ports:
//     clk, rst  : clock, synchronous active-high reset
//     set       : write set_dat, entry becomes valid next cycle
//     clr       : entry drained, valid drops next cycle
//     set_dat   : result to store
//     vld, dat  : current entry state
//   set and clr never target the same entry in one cycle (a valid entry
//   refuses writes); set is given precedence anyway.
// ---------------------------------------------------------------------------
module e203_exu_longp_rob_slot
    import e203_longp_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       set,
    input  logic       clr,
    input  longp_res_t set_dat,
    output logic       vld,
    output longp_res_t dat
);

    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= 1'b0;
            dat <= '0;
        end else if (set) begin
            vld <= 1'b1;
            dat <= set_dat;
        end else if (clr) begin
            vld <= 1'b0;
        end
    end

endmodule

// File: rtl/e203_exu_longp_wbck_rob.sv
// ---------------------------------------------------------------------------
// e203_exu_longp_wbck_rob
//   Collects out-of-order long-pipe results (src0 = LSU/AGU, src1 = FPU/MulDiv)
//   into slots indexed by OITF tag and releases them strictly in OITF order.
//   Ports:
//     src0_* / src1_*   : result inputs with valid/ready, tagged by itag
//     oitf_ret_ptr      : OITF head tag, selects the head slot
//     oitf_empty        : OITF holds nothing; suppresses all output
//     oitf_ret_ena      : retire pulse, high in the cycle a result drains
//     longp_wbck_o_*    : regfile write-back stream (err = 0 results)
//     longp_excp_o_*    : exception report (err = 1 results)
//   Handshakes: a transfer happens in a cycle where valid and ready are both
//   high; valid never depends on ready, and an offered output stays valid with
//   stable data until it transfers (or reset).
//   Optional macro E203_LONGP_WBCK_BYPASS_EN: a head-tagged, error-free input
//   arriving while the head slot is empty is forwarded in the same cycle; if
//   the arbiter takes it the slot is never written.
// ---------------------------------------------------------------------------
module e203_exu_longp_wbck_rob
    import e203_longp_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int ITAG_W  = 1,
    parameter int FLEN    = LONGP_FLEN,
    parameter int RFIDX_W = LONGP_RFIDX_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     src0_valid,
    output logic                     src0_ready,
    input  logic [FLEN-1:0]          src0_wdat,
    input  logic [LONGP_FLAGS_W-1:0] src0_flags,
    input  logic [RFIDX_W-1:0]       src0_rdidx,
    input  logic                     src0_rdfpu,
    input  logic                     src0_err,
    input  logic [ITAG_W-1:0]        src0_itag,
    input  logic                     src1_valid,
    output logic                     src1_ready,
    input  logic [FLEN-1:0]          src1_wdat,
    input  logic [LONGP_FLAGS_W-1:0] src1_flags,
    input  logic [RFIDX_W-1:0]       src1_rdidx,
    input  logic                     src1_rdfpu,
    input  logic                     src1_err,
    input  logic [ITAG_W-1:0]        src1_itag,
    input  logic [ITAG_W-1:0]        oitf_ret_ptr,
    input  logic                     oitf_empty,
    output logic                     oitf_ret_ena,
    output logic                     longp_wbck_o_valid,
    input  logic                     longp_wbck_o_ready,
    output logic [FLEN-1:0]          longp_wbck_o_wdat,
    output logic [LONGP_FLAGS_W-1:0] longp_wbck_o_flags,
    output logic [RFIDX_W-1:0]       longp_wbck_o_rdidx,
    output logic                     longp_wbck_o_rdfpu,
    output logic                     longp_excp_o_valid,
    input  logic                     longp_excp_o_ready
);

    longp_res_t       src0_res, src1_res;
    logic [DEPTH-1:0] slot_vld;
    longp_res_t       slot_dat [DEPTH];

    logic       src0_hsk, src1_hsk;
    logic       head_act;
    longp_res_t head_res;
    logic       drain, slot_drain;
    logic       byp0, byp1, byp_vld;
    longp_res_t byp_res, out_res;

    assign src0_res = '{wdat: src0_wdat, flags: src0_flags, rdidx: src0_rdidx,
                        rdfpu: src0_rdfpu, err: src0_err};
    assign src1_res = '{wdat: src1_wdat, flags: src1_flags, rdidx: src1_rdidx,
                        rdfpu: src1_rdfpu, err: src1_err};

    // A slot takes a new result only while empty; on a tag collision src1
    // yields so both sources never write the same slot in one cycle.
    assign src0_ready = ~rst & ~slot_vld[src0_itag];
    assign src1_ready = ~rst & ~slot_vld[src1_itag]
                      & ~(src0_valid & (src0_itag == src1_itag));
    assign src0_hsk   = src0_valid & src0_ready;
    assign src1_hsk   = src1_valid & src1_ready;

    // Head slot is offered only while the OITF actually has an entry; a stale
    // valid slot with an empty OITF is held, not released.
    assign head_act = ~rst & slot_vld[oitf_ret_ptr] & ~oitf_empty;
    assign head_res = slot_dat[oitf_ret_ptr];

`ifdef E203_LONGP_WBCK_BYPASS_EN
    logic byp_en;
    assign byp_en  = ~rst & ~slot_vld[oitf_ret_ptr] & ~oitf_empty;
    assign byp0    = byp_en & src0_hsk & (src0_itag == oitf_ret_ptr) & ~src0_err;
    assign byp1    = byp_en & src1_hsk & (src1_itag == oitf_ret_ptr) & ~src1_err & ~byp0;
    assign byp_vld = byp0 | byp1;
    assign byp_res = byp0 ? src0_res : src1_res;
`else
    assign byp0    = 1'b0;
    assign byp1    = 1'b0;
    assign byp_vld = 1'b0;
    assign byp_res = '0;
`endif

    // Data outputs are zero whenever nothing is being offered.
    assign out_res = head_act ? head_res : (byp_vld ? byp_res : '0);

    assign longp_wbck_o_valid = (head_act & ~head_res.err) | byp_vld;
    assign longp_excp_o_valid = head_act & head_res.err;
    assign longp_wbck_o_wdat  = out_res.wdat;
    assign longp_wbck_o_flags = out_res.flags;
    assign longp_wbck_o_rdidx = out_res.rdidx;
    assign longp_wbck_o_rdfpu = out_res.rdfpu;

    assign drain        = (longp_wbck_o_valid & longp_wbck_o_ready)
                        | (longp_excp_o_valid & longp_excp_o_ready);
    assign oitf_ret_ena = drain;
    assign slot_drain   = drain & head_act;

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic       hit0, hit1, set, clr;
        longp_res_t set_dat;

        // A forwarded result that retires immediately never lands in a slot.
        assign hit0    = src0_hsk & (src0_itag == ITAG_W'(i)) & ~(byp0 & longp_wbck_o_ready);
        assign hit1    = src1_hsk & (src1_itag == ITAG_W'(i)) & ~(byp1 & longp_wbck_o_ready);
        assign set     = hit0 | hit1;
        assign set_dat = (longp_src_sel(hit0) == LONGP_SRC0) ? src0_res : src1_res;
        assign clr     = slot_drain & (oitf_ret_ptr == ITAG_W'(i));

        e203_exu_longp_rob_slot u_slot (
            .clk     (clk),
            .rst     (rst),
            .set     (set),
            .clr     (clr),
            .set_dat (set_dat),
            .vld     (slot_vld[i]),
            .dat     (slot_dat[i])
        );
    end

endmodule

// File: tb/tb_e203_exu_longp_wbck_rob.sv
// ---------------------------------------------------------------------------
// tb_e203_exu_longp_wbck_rob
//   Directed steps followed by random traffic. The bench acts as the OITF:
//   it owns the retire pointer and advances it whenever a result retires.
//   A table of per-tag result entries (the expected buffer contents) gives
//   the expected outputs each cycle.
// ---------------------------------------------------------------------------
module tb_e203_exu_longp_wbck_rob;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // ---------------- DUT signals ----------------
    logic        src0_valid, src0_ready, src0_rdfpu, src0_err;
    logic [31:0] src0_wdat;
    logic [4:0]  src0_flags, src0_rdidx;
    logic [0:0]  src0_itag;
    logic        src1_valid, src1_ready, src1_rdfpu, src1_err;
    logic [31:0] src1_wdat;
    logic [4:0]  src1_flags, src1_rdidx;
    logic [0:0]  src1_itag;
    logic [0:0]  oitf_ret_ptr;
    logic        oitf_empty, oitf_ret_ena;
    logic        longp_wbck_o_valid, longp_wbck_o_ready, longp_wbck_o_rdfpu;
    logic [31:0] longp_wbck_o_wdat;
    logic [4:0]  longp_wbck_o_flags, longp_wbck_o_rdidx;
    logic        longp_excp_o_valid, longp_excp_o_ready;

    e203_exu_longp_wbck_rob dut (
        .clk(clk), .rst(rst),
        .src0_valid(src0_valid), .src0_ready(src0_ready), .src0_wdat(src0_wdat),
        .src0_flags(src0_flags), .src0_rdidx(src0_rdidx), .src0_rdfpu(src0_rdfpu),
        .src0_err(src0_err), .src0_itag(src0_itag),
        .src1_valid(src1_valid), .src1_ready(src1_ready), .src1_wdat(src1_wdat),
        .src1_flags(src1_flags), .src1_rdidx(src1_rdidx), .src1_rdfpu(src1_rdfpu),
        .src1_err(src1_err), .src1_itag(src1_itag),
        .oitf_ret_ptr(oitf_ret_ptr), .oitf_empty(oitf_empty), .oitf_ret_ena(oitf_ret_ena),
        .longp_wbck_o_valid(longp_wbck_o_valid), .longp_wbck_o_ready(longp_wbck_o_ready),
        .longp_wbck_o_wdat(longp_wbck_o_wdat), .longp_wbck_o_flags(longp_wbck_o_flags),
        .longp_wbck_o_rdidx(longp_wbck_o_rdidx), .longp_wbck_o_rdfpu(longp_wbck_o_rdfpu),
        .longp_excp_o_valid(longp_excp_o_valid), .longp_excp_o_ready(longp_excp_o_ready)
    );

    // ---------------- reference model ----------------
    logic        m_vld   [2];
    logic [31:0] m_wdat  [2];
    logic [4:0]  m_flags [2];
    logic [4:0]  m_rdidx [2];
    logic        m_rdfpu [2];
    logic        m_err   [2];
    logic [0:0]  ptr;

    logic        e_wv, e_ev, e_r0, e_r1, e_rdfpu;
    logic [31:0] e_wdat;
    logic [4:0]  e_flags, e_rdidx;
    logic        hs0, hs1, drain, byp0, byp1;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Evaluate expected outputs for the currently driven inputs and compare.
    task automatic eval();
        #3;
        hs0 = 0; hs1 = 0; drain = 0; byp0 = 0; byp1 = 0;
        e_wv = 0; e_ev = 0; e_r0 = 0; e_r1 = 0;
        e_wdat = 0; e_flags = 0; e_rdidx = 0; e_rdfpu = 0;
        if (!rst) begin
            e_r0 = !m_vld[src0_itag];
            e_r1 = !m_vld[src1_itag] && !(src0_valid && src0_itag == src1_itag);
            hs0  = src0_valid && e_r0;
            hs1  = src1_valid && e_r1;
            if (m_vld[ptr] && !oitf_empty) begin
                e_wv = !m_err[ptr];
                e_ev = m_err[ptr];
                e_wdat = m_wdat[ptr]; e_flags = m_flags[ptr];
                e_rdidx = m_rdidx[ptr]; e_rdfpu = m_rdfpu[ptr];
            end
`ifdef E203_LONGP_WBCK_BYPASS_EN
            else if (!m_vld[ptr] && !oitf_empty) begin
                byp0 = hs0 && src0_itag == ptr && !src0_err;
                byp1 = !byp0 && hs1 && src1_itag == ptr && !src1_err;
                if (byp0) begin
                    e_wv = 1; e_wdat = src0_wdat; e_flags = src0_flags;
                    e_rdidx = src0_rdidx; e_rdfpu = src0_rdfpu;
                end else if (byp1) begin
                    e_wv = 1; e_wdat = src1_wdat; e_flags = src1_flags;
                    e_rdidx = src1_rdidx; e_rdfpu = src1_rdfpu;
                end
            end
`endif
            drain = (e_wv && longp_wbck_o_ready) || (e_ev && longp_excp_o_ready);
        end
        check("wbck_valid", longp_wbck_o_valid, e_wv);
        check("excp_valid", longp_excp_o_valid, e_ev);
        check("wdat",       longp_wbck_o_wdat,  e_wdat);
        check("flags",      longp_wbck_o_flags, e_flags);
        check("rdidx",      longp_wbck_o_rdidx, e_rdidx);
        check("rdfpu",      longp_wbck_o_rdfpu, e_rdfpu);
        check("ret_ena",    oitf_ret_ena,       drain);
        check("src0_ready", src0_ready,         e_r0);
        check("src1_ready", src1_ready,         e_r1);
    endtask

    // Cross the clock edge and apply the cycle's effects to the model.
    task automatic advance();
        @(posedge clk);
        #1;
        if (rst) begin
            for (int i = 0; i < 2; i++) m_vld[i] = 0;
            ptr = 0;
        end else begin
            if (drain) begin
                if (!(byp0 || byp1)) m_vld[ptr] = 0;
                ptr = ptr + 1'b1;
            end
            if (hs0 && !(byp0 && drain)) begin
                m_vld[src0_itag] = 1; m_wdat[src0_itag] = src0_wdat;
                m_flags[src0_itag] = src0_flags; m_rdidx[src0_itag] = src0_rdidx;
                m_rdfpu[src0_itag] = src0_rdfpu; m_err[src0_itag] = src0_err;
            end
            if (hs1 && !(byp1 && drain)) begin
                m_vld[src1_itag] = 1; m_wdat[src1_itag] = src1_wdat;
                m_flags[src1_itag] = src1_flags; m_rdidx[src1_itag] = src1_rdidx;
                m_rdfpu[src1_itag] = src1_rdfpu; m_err[src1_itag] = src1_err;
            end
        end
        oitf_ret_ptr = ptr;
    endtask

    task automatic tick();
        eval();
        advance();
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive0(input logic v, input logic [0:0] tag, input logic [31:0] d, input logic e);
        src0_valid = v; src0_itag = tag; src0_wdat = d; src0_err = e;
        src0_flags = d[4:0]; src0_rdidx = d[9:5]; src0_rdfpu = d[10];
    endtask

    task automatic drive1(input logic v, input logic [0:0] tag, input logic [31:0] d, input logic e);
        src1_valid = v; src1_itag = tag; src1_wdat = d; src1_err = e;
        src1_flags = d[4:0]; src1_rdidx = d[9:5]; src1_rdfpu = d[10];
    endtask

    task automatic idle();
        drive0(0, 0, 32'h0, 0);
        drive1(0, 1, 32'h0, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 2; i++) begin
            m_vld[i] = 0; m_wdat[i] = 0; m_flags[i] = 0;
            m_rdidx[i] = 0; m_rdfpu[i] = 0; m_err[i] = 0;
        end
        ptr = 0;
        rst = 1; oitf_ret_ptr = 0; oitf_empty = 0;
        longp_wbck_o_ready = 0; longp_excp_o_ready = 0;
        idle();
        @(posedge clk);
        #1;

        // Reset state
        tick();
        rst = 0;
        eval();
        check("rst_src0_ready", src0_ready, 1'b1);
        check("rst_src1_ready", src1_ready, 1'b1);
        check("rst_wbck_valid", longp_wbck_o_valid, 1'b0);
        check("rst_ret_ena", oitf_ret_ena, 1'b0);
        advance();

        // In-order retire
        longp_wbck_o_ready = 1;
        drive0(1, 0, 32'h11, 0);
        tick();
        idle();
        drive1(1, 1, 32'h22, 0);
        eval();
        check("inorder_ret1", oitf_ret_ena, 1'b1);
`ifdef E203_LONGP_WBCK_BYPASS_EN
        check("inorder_wdat1", longp_wbck_o_wdat, 32'h22);
`else
        check("inorder_wdat1", longp_wbck_o_wdat, 32'h11);
`endif
        advance();
        idle();
        tick();

        // Out-of-order arrival
        drive1(1, 1, 32'hBB, 0);
        eval();
        check("ooo_no_out", longp_wbck_o_valid, 1'b0);
        advance();
        idle();
        drive0(1, 0, 32'hAA, 0);
        tick();
        idle();
        tick();
        tick();

        // Backpressure and full buffer
        longp_wbck_o_ready = 0;
        drive0(1, 0, 32'h33, 0);
        tick();
        idle();
        drive1(1, 1, 32'h44, 0);
        for (int i = 0; i < 5; i++) begin
            eval();
            check("bp_valid", longp_wbck_o_valid, 1'b1);
            check("bp_ret", oitf_ret_ena, 1'b0);
            advance();
            idle();
        end
        drive0(1, 0, 32'h55, 0);
        drive1(1, 1, 32'h66, 0);
        eval();
        check("full_src0_ready", src0_ready, 1'b0);
        check("full_src1_ready", src1_ready, 1'b0);
        advance();
        idle();
        longp_wbck_o_ready = 1;
        tick();
        tick();
        tick();

        // Tag collision: src0 wins, src1 waits for the slot to drain
        longp_wbck_o_ready = 0;
        drive0(1, 1, 32'h155, 0);
        drive1(1, 1, 32'h166, 0);
        eval();
        check("coll_src0_ready", src0_ready, 1'b1);
        check("coll_src1_ready", src1_ready, 1'b0);
        advance();
        drive0(1, 0, 32'h177, 0);
        tick();
        drive0(0, 0, 32'h0, 0);
        longp_wbck_o_ready = 1;
        for (int i = 0; i < 4; i++) tick();
        idle();
        for (int i = 0; i < 3; i++) tick();

        // Exception result
        longp_excp_o_ready = 0;
        drive0(1, ptr, 32'h99, 1);
        tick();
        idle();
        eval();
        check("excp_valid_on", longp_excp_o_valid, 1'b1);
        check("excp_no_wbck", longp_wbck_o_valid, 1'b0);
        check("excp_hold_ret", oitf_ret_ena, 1'b0);
        advance();
        longp_excp_o_ready = 1;
        eval();
        check("excp_ret", oitf_ret_ena, 1'b1);
        advance();
        eval();
        check("excp_cleared", longp_excp_o_valid, 1'b0);
        advance();

        // OITF empty holds a stale entry
        oitf_empty = 1;
        drive0(1, ptr, 32'h1CC, 0);
        tick();
        idle();
        eval();
        check("empty_no_out", longp_wbck_o_valid, 1'b0);
        advance();
        oitf_empty = 0;
        tick();
        tick();

        // Reset mid-stream
        longp_wbck_o_ready = 0;
        drive0(1, 0, 32'h1DD, 0);
        drive1(1, 1, 32'h1EE, 0);
        tick();
        idle();
        tick();
        rst = 1;
        tick();
        rst = 0;
        eval();
        check("mid_rst_src0_ready", src0_ready, 1'b1);
        check("mid_rst_src1_ready", src1_ready, 1'b1);
        check("mid_rst_wbck_valid", longp_wbck_o_valid, 1'b0);
        check("mid_rst_excp_valid", longp_excp_o_valid, 1'b0);
        advance();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            oitf_empty = ($urandom_range(0, 15) == 0);
            longp_wbck_o_ready = $urandom_range(0, 1);
            longp_excp_o_ready = $urandom_range(0, 1);
            drive0($urandom_range(0, 1), 1'($urandom_range(0, 1)), $urandom,
                   ($urandom_range(0, 7) == 0));
            drive1($urandom_range(0, 1), 1'($urandom_range(0, 1)), $urandom,
                   ($urandom_range(0, 7) == 0));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/e203_exu_longp_wbck_rob.md
Name: e203_exu_longp_wbck_rob

Overview:
- Reorder/collect buffer that produces the long-pipe write-back stream consumed by the final write-back arbiter (longp_wbck_o_* valid/ready, wdat, flags, rdidx, rdfpu).
- Accepts out-of-order results from two long-pipe sources (src0 = LSU/AGU, src1 = FPU/MulDiv), each tagged with its OITF index (itag).
- Releases results strictly in OITF order and pulses OITF retire on each drain.

Parameters:
- DEPTH, 2, entries; equals OITF depth, power of 2.
- ITAG_W, 1, log2(DEPTH).
- FLEN, 32, result data width.
- RFIDX_W, 5, register index width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- src0_valid  in  1  source 0 result valid
- src0_ready  out  1  source 0 accept
- src0_wdat  in  FLEN  result data
- src0_flags  in  5  FP exception flags
- src0_rdidx  in  RFIDX_W  destination register
- src0_rdfpu  in  1  destination is FP regfile
- src0_err  in  1  result carries exception
- src0_itag  in  ITAG_W  OITF index
- src1_* : same set as src0_*
- oitf_ret_ptr  in  ITAG_W  OITF head index
- oitf_empty  in  1  OITF has no outstanding entry
- oitf_ret_ena  out  1  retire pulse to OITF
- longp_wbck_o_valid  out  1  to write-back arbiter
- longp_wbck_o_ready  in  1  from arbiter
- longp_wbck_o_wdat  out  FLEN
- longp_wbck_o_flags  out  5
- longp_wbck_o_rdidx  out  RFIDX_W
- longp_wbck_o_rdfpu  out  1
- longp_excp_o_valid  out  1  exception report to commit
- longp_excp_o_ready  in  1

Behaviour:
- Clocking: one clock `clk`. Reset `rst` is synchronous and active-high. All state is in the `clk` domain.
- Storage: DEPTH slots indexed by itag. Each slot holds vld, wdat, flags, rdidx, rdfpu, err.
- Reset: all vld cleared. All valid outputs and oitf_ret_ena are 0. Data outputs are 0 while head slot vld=0 (gated).
- Accept:
  - srcN_ready = ~slot[srcN_itag].vld.
  - src1_ready is additionally forced low when src0_valid and src0_itag == src1_itag (src0 priority).
  - On handshake the slot is written at the clk edge; vld=1 from the next cycle. Minimum latency input to output is 1 cycle.
- Head: H = slot[oitf_ret_ptr].
  - Output is active only if H.vld & ~oitf_empty.
  - If H.err=0: longp_wbck_o_valid=1 and the data fields come from H.
  - If H.err=1: longp_excp_o_valid=1 and longp_wbck_o_valid=0 (no regfile write).
- Drain:
  - Drain occurs when (longp_wbck_o_valid & longp_wbck_o_ready) or (longp_excp_o_valid & longp_excp_o_ready).
  - On drain, oitf_ret_ena=1 that same cycle (combinational) and H.vld clears at the edge.
  - At most one drain per cycle.
- Simultaneous events:
  - A write to the head slot in the same cycle it drains is impossible, because ready is low while vld=1.
  - Writes to other slots proceed in parallel with a drain.
  - Two sources writing distinct slots in one cycle are both accepted.
- Boundary conditions:
  - All slots full: both readies low until a drain.
  - oitf_empty=1: no output, even with stale vld (protocol error; the entry is held).
  - Reset mid-operation discards all buffered entries.
- Output valid is held with stable data until accepted; it never drops without a handshake except on reset.

Optional Feature:
- Macro: E203_LONGP_WBCK_BYPASS_EN.
- Defined: when H.vld=0 and a source handshakes with itag == oitf_ret_ptr and err=0, its fields drive longp_wbck_o_* in the same cycle.
  - src0 is preferred if both sources match.
  - If longp_wbck_o_ready=1, the result drains with oitf_ret_ena=1 and the slot is not written.
  - Otherwise the slot is written normally.
  - Latency becomes 0 cycles.
- Undefined: no bypass; latency is always ≥1 cycle. Output is purely from slot state, which eases timing.

Decomposition:
- Shared package `e203_longp_pkg` holds:
  - the result struct (wdat, flags, rdidx, rdfpu, err);
  - the constants LONGP_FLAGS_W=5 and the src0 priority encoding.
- One natural sub-module, `e203_exu_longp_rob_slot`: a single entry with set/clear/vld logic and a data register, instantiated DEPTH times.

Test Plan:
- In-order retire: src0 itag0 wdat=0x11, cycle 1 src1 itag1 wdat=0x22, ready=1 → wbck_o wdat 0x11 then 0x22 on consecutive cycles with ret_ptr 0→1; oitf_ret_ena pulses twice.
- Out-of-order: src1 itag1 wdat=0xBB first, then src0 itag0 wdat=0xAA, ret_ptr=0 → no output until 0xAA is buffered; output order is 0xAA then 0xBB.
- Backpressure: head valid, longp_wbck_o_ready=0 for 5 cycles → valid/data stable, oitf_ret_ena=0; full buffer drives src0_ready=src1_ready=0.
- Collision: both sources valid with itag=1 and slot1 empty → src0 accepted, src1_ready=0; src1 accepted the cycle after slot1 drains.
- Exception: src0 err=1 itag0 → longp_excp_o_valid=1, longp_wbck_o_valid=0; on excp_ready=1, oitf_ret_ena=1 and the slot clears.
- Reset mid-stream: rst=1 with 2 slots valid → next cycle all valids are 0 and the readies are 1. With BYPASS_EN defined: head-matching input with ready=1 → output and ret in the same cycle.
